mux_scan_ctrl: RTL and testbench

- Sequencer directly upstream of the 4-bit 5:1 multiplexer (mux_5_1).
- Drives the mux select line, waits a programmable settle time, then captures the mux output into a register.
- Sweeps all inputs either automatically (auto mode) or one input per step pulse (manual mode).
- Feeds captured samples, tagged with their source index, to downstream display and check logic.

---
 rtl/mux_scan_ctrl.sv | 140 ++++++++++++++
 tb/tb_mux_scan_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_ctrl.sv
// Select sequencer for a 5:1 mux: drives sel, waits DWELL cycles, captures the sample.
// Optional per-frame running maximum output enabled by MUX_SCAN_FRAME_MAX_EN.
module mux_scan_ctrl #(
    parameter int unsigned N_INPUTS = 5,
    parameter int unsigned SEL_W    = 3,
    parameter int unsigned DATA_W   = 4,
    parameter int unsigned DWELL    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              mode,
    input  logic              step,
    output logic [SEL_W-1:0]  sel,
    input  logic [DATA_W-1:0] mux_out,
    output logic [DATA_W-1:0] data_out,
    output logic [SEL_W-1:0]  data_idx,
    output logic              data_valid,
`ifdef MUX_SCAN_FRAME_MAX_EN
    output logic [DATA_W-1:0] frame_max,
`endif
    output logic              frame_done
);

    localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N_INPUTS - 1);
    localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic [SEL_W-1:0]  data_idx_q, data_idx_d;
    logic              data_valid_q, data_valid_d;
    logic              frame_done_q, frame_done_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            sel_q        <= '0;
            data_out_q   <= '0;
            data_idx_q   <= '0;
            data_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sel_q        <= sel_d;
            data_out_q   <= data_out_d;
            data_idx_q   <= data_idx_d;
            data_valid_q <= data_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Scan sequencing: SETTLE holds sel for DWELL cycles, CAPTURE samples and advances
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sel_d        = sel_q;
        data_out_d   = data_out_q;
        data_idx_d   = data_idx_q;
        data_valid_d = 1'b0;
        frame_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && (!mode || step)) begin
                    state_d = SETTLE;
                    cnt_d   = DWELL_LD;
                end
            end
            SETTLE: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = CAPTURE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            CAPTURE: begin
                data_out_d   = mux_out;
                data_idx_d   = sel_q;
                data_valid_d = 1'b1;
                frame_done_d = (sel_q == LAST_SEL);
                sel_d        = (sel_q == LAST_SEL) ? '0 : sel_q + SEL_W'(1);
                if (enable && !mode) begin
                    state_d = SETTLE;
                    cnt_d   = DWELL_LD;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign sel        = sel_q;
    assign data_out   = data_out_q;
    assign data_idx   = data_idx_q;
    assign data_valid = data_valid_q;
    assign frame_done = frame_done_q;

`ifdef MUX_SCAN_FRAME_MAX_EN
    logic [DATA_W-1:0] run_max_q, run_max_d;
    logic [DATA_W-1:0] frame_max_q, frame_max_d;
    logic [DATA_W-1:0] cap_max_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_max_q   <= '0;
            frame_max_q <= '0;
        end else begin
            run_max_q   <= run_max_d;
            frame_max_q <= frame_max_d;
        end
    end

    // Running max folds in every capture; published and cleared on the last input
    always_comb begin
        run_max_d   = run_max_q;
        frame_max_d = frame_max_q;
        cap_max_c   = (mux_out > run_max_q) ? mux_out : run_max_q;
        if (state_q == CAPTURE) begin
            if (sel_q == LAST_SEL) begin
                frame_max_d = cap_max_c;
                run_max_d   = '0;
            end else begin
                run_max_d = cap_max_c;
            end
        end
    end

    assign frame_max = frame_max_q;
`endif

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: a 5-input and a 3-input instance share control inputs.
// Frame-max checks are active when MUX_SCAN_FRAME_MAX_EN is defined.
module tb_mux_scan_ctrl;

    logic       clk = 1'b0;
    logic       reset, enable, mode, step;
    logic [2:0] sel5, idx5, sel3, idx3;
    logic [3:0] mux5, mux3, dout5, dout3;
    logic       valid5, fd5, valid3, fd3;
    logic [3:0] vals [8];
    logic [2:0] max_sel3 = 3'd0;
    int         checks = 0;
    int         failures = 0;
`ifdef MUX_SCAN_FRAME_MAX_EN
    logic [3:0] fmax5, fmax3;
`endif

    always #5 clk = ~clk;

    always_comb mux5 = vals[sel5];
    always_comb mux3 = vals[sel3];

    mux_scan_ctrl #(.N_INPUTS(5), .SEL_W(3), .DATA_W(4), .DWELL(2)) dut5 (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode), .step(step),
        .sel(sel5), .mux_out(mux5), .data_out(dout5), .data_idx(idx5),
        .data_valid(valid5),
`ifdef MUX_SCAN_FRAME_MAX_EN
        .frame_max(fmax5),
`endif
        .frame_done(fd5));

    mux_scan_ctrl #(.N_INPUTS(3), .SEL_W(3), .DATA_W(4), .DWELL(2)) dut3 (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode), .step(step),
        .sel(sel3), .mux_out(mux3), .data_out(dout3), .data_idx(idx3),
        .data_valid(valid3),
`ifdef MUX_SCAN_FRAME_MAX_EN
        .frame_max(fmax3),
`endif
        .frame_done(fd3));

    always @(negedge clk) if (sel3 > max_sel3) max_sel3 = sel3;

    typedef struct {
        int         gap;
        logic [2:0] idx;
        logic [3:0] data;
        logic       fd;
        logic [2:0] idx3;
        logic [3:0] data3;
        logic       fd3;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until data_valid from the 5-input instance; gap returns cycles taken
    task automatic wait_valid(input int maxc, output int gap);
        gap = -1;
        for (int c = 1; c <= maxc; c++) begin
            tick();
            if (valid5) begin
                gap = c;
                break;
            end
        end
        if (gap < 0) chk("valid_timeout", 32'(0), 32'(1));
    endtask

    task automatic do_reset();
        enable = 1'b0; mode = 1'b0; step = 1'b0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
    endtask

    int gap;
    int vcnt;

    initial begin
        vals[0] = 4'h8; vals[1] = 4'hF; vals[2] = 4'h3; vals[3] = 4'h2;
        vals[4] = 4'h5; vals[5] = 4'h0; vals[6] = 4'h0; vals[7] = 4'h0;

        tbl[0] = '{4, 3'd0, 4'h8, 1'b0, 3'd0, 4'h8, 1'b0};
        tbl[1] = '{3, 3'd1, 4'hF, 1'b0, 3'd1, 4'hF, 1'b0};
        tbl[2] = '{3, 3'd2, 4'h3, 1'b0, 3'd2, 4'h3, 1'b1};
        tbl[3] = '{3, 3'd3, 4'h2, 1'b0, 3'd0, 4'h8, 1'b0};
        tbl[4] = '{3, 3'd4, 4'h5, 1'b1, 3'd1, 4'hF, 1'b0};
        tbl[5] = '{3, 3'd0, 4'h8, 1'b0, 3'd2, 4'h3, 1'b1};

        enable = 1'b0; mode = 1'b0; step = 1'b0; reset = 1'b1;
        tick(); tick();
        chk("rst_sel", 32'(sel5), 32'(0));
        chk("rst_data_out", 32'(dout5), 32'(0));
        chk("rst_data_idx", 32'(idx5), 32'(0));
        chk("rst_valid", 32'(valid5), 32'(0));
        chk("rst_frame_done", 32'(fd5), 32'(0));

        // Auto scan: both instances in lockstep, period DWELL+1, first after DWELL+2
        reset = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wait_valid(20, gap);
            chk($sformatf("auto_gap[%0d]", i), 32'(gap), 32'(tbl[i].gap));
            chk($sformatf("auto_idx[%0d]", i), 32'(idx5), 32'(tbl[i].idx));
            chk($sformatf("auto_data[%0d]", i), 32'(dout5), 32'(tbl[i].data));
            chk($sformatf("auto_fd[%0d]", i), 32'(fd5), 32'(tbl[i].fd));
            chk($sformatf("n3_valid[%0d]", i), 32'(valid3), 32'(1));
            chk($sformatf("n3_idx[%0d]", i), 32'(idx3), 32'(tbl[i].idx3));
            chk($sformatf("n3_data[%0d]", i), 32'(dout3), 32'(tbl[i].data3));
            chk($sformatf("n3_fd[%0d]", i), 32'(fd3), 32'(tbl[i].fd3));
        end
        chk("n3_sel_max", 32'(max_sel3), 32'(2));

        // Manual step mode
        do_reset();
        mode = 1'b1; enable = 1'b1;
        vcnt = 0;
        for (int i = 0; i < 3; i++) begin tick(); vcnt += int'(valid5); end
        chk("man_no_step_valid", 32'(vcnt), 32'(0));
        chk("man_no_step_sel", 32'(sel5), 32'(0));
        step = 1'b1; tick(); step = 1'b0;
        tick();
        chk("man_settle_sel", 32'(sel5), 32'(0));
        chk("man_settle_valid", 32'(valid5), 32'(0));
        step = 1'b1; tick(); step = 1'b0;
        tick();
        chk("man1_valid", 32'(valid5), 32'(1));
        chk("man1_idx", 32'(idx5), 32'(0));
        chk("man1_data", 32'(dout5), 32'(8));
        chk("man1_sel", 32'(sel5), 32'(1));
        vcnt = 0;
        for (int i = 0; i < 6; i++) begin tick(); vcnt += int'(valid5); end
        chk("man_extra_valid", 32'(vcnt), 32'(0));
        chk("man_idle_sel", 32'(sel5), 32'(1));
        step = 1'b1; tick(); step = 1'b0;
        wait_valid(10, gap);
        chk("man2_gap", 32'(gap), 32'(3));
        chk("man2_idx", 32'(idx5), 32'(1));
        chk("man2_data", 32'(dout5), 32'(15));

        // Enable dropped during SETTLE at sel=2
        do_reset();
        enable = 1'b1;
        wait_valid(20, gap);
        wait_valid(20, gap);
        chk("abort_pre_idx", 32'(idx5), 32'(1));
        enable = 1'b0;
        vcnt = 0;
        for (int i = 0; i < 6; i++) begin tick(); vcnt += int'(valid5); end
        chk("abort_valid", 32'(vcnt), 32'(0));
        chk("abort_sel", 32'(sel5), 32'(2));
        enable = 1'b1;
        wait_valid(20, gap);
        chk("resume_gap", 32'(gap), 32'(4));
        chk("resume_idx", 32'(idx5), 32'(2));
        chk("resume_data", 32'(dout5), 32'(3));

        // Asynchronous reset in CAPTURE at sel=3
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 3; i++) wait_valid(20, gap);
        chk("rstcap_pre_idx", 32'(idx5), 32'(2));
        tick(); tick();
        #2 reset = 1'b1;
        #1;
        chk("rstcap_sel", 32'(sel5), 32'(0));
        chk("rstcap_data_out", 32'(dout5), 32'(0));
        chk("rstcap_data_idx", 32'(idx5), 32'(0));
        chk("rstcap_valid", 32'(valid5), 32'(0));
        chk("rstcap_fd", 32'(fd5), 32'(0));
        tick();
        chk("rstcap_edge_valid", 32'(valid5), 32'(0));
        reset = 1'b0;
        wait_valid(20, gap);
        chk("rstcap_after_gap", 32'(gap), 32'(4));
        chk("rstcap_after_idx", 32'(idx5), 32'(0));
        chk("rstcap_after_data", 32'(dout5), 32'(8));

`ifdef MUX_SCAN_FRAME_MAX_EN
        // Frame maximum published only at frame end
        do_reset();
        chk("fmax_rst", 32'(fmax5), 32'(0));
        enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wait_valid(20, gap);
            if (i < 4)
                chk($sformatf("fmax_first[%0d]", i), 32'(fmax5), 32'(0));
            else if (i < 9)
                chk($sformatf("fmax_hold[%0d]", i), 32'(fmax5), 32'(15));
            else
                chk("fmax_second", 32'(fmax5), 32'(8));
            if (i == 4) vals[1] = 4'h6;
        end
        vals[1] = 4'hF;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
